rsa_expo_sched: RTL

- Left-to-right binary exponentiation sequencer for the Montgomery multiplier datapath.
- Pulls 32-bit exponent words MSB-word-first from the masked-exponent FIFO.
- Skips leading zero bits, then issues square/multiply operations to the MM engine over a start/done handshake.
- Brackets the run with conversion into and out of the Montgomery domain; an optional dummy multiply gives constant-time operation.

---
 rtl/rsa_expo_sched.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/rsa_expo_sched.sv
// Left-to-right binary exponentiation sequencer: reads exponent words MSB-word-first,
// skips leading zeros, and drives square/multiply operations into the Montgomery engine.
module rsa_expo_sched #(
   parameter int EXP_WORDS = 32,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             start,
   input  logic             dummy_en,
   input  logic             expo_empty,
   input  logic [31:0]      expo_data,
   output logic             expo_rd_en,
   output logic             mm_start,
   output logic [2:0]       mm_op,
   input  logic             mm_done,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [CNT_W-1:0] op_cnt,
   output logic [3:0]       dbg_state
);

   localparam int WW = (EXP_WORDS > 1) ? $clog2(EXP_WORDS) : 1;
   localparam logic [WW-1:0] LAST_WORD = WW'(EXP_WORDS - 1);

   localparam logic [2:0] OP_CONV_IN  = 3'd0;
   localparam logic [2:0] OP_SQR      = 3'd1;
   localparam logic [2:0] OP_MUL      = 3'd2;
   localparam logic [2:0] OP_DUMMY    = 3'd3;
   localparam logic [2:0] OP_CONV_OUT = 3'd4;

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_ISSUE  = 4'd1,
      S_WAIT   = 4'd2,
      S_FETCH  = 4'd3,
      S_LOAD   = 4'd4,
      S_SCAN   = 4'd5,
      S_MULCHK = 4'd6,
      S_ADV    = 4'd7,
      S_FIN    = 4'd8
   } state_t;

   state_t           state_q;
   logic [2:0]       mm_op_q;
   logic [CNT_W-1:0] op_cnt_q;
   logic [CNT_W-1:0] op_cnt_d;
   logic [WW-1:0]    word_q;
   logic [4:0]       bit_q;
   logic [31:0]      sh_q;
   logic             found_q;
   logic             dummy_q;
   logic             mm_start_q;
   logic             busy_q;
   logic             done_q;
   logic             err_q;

   // Handshakes: mm_start is a one-cycle launch with mm_op stable until the engine's
   // one-cycle mm_done, which only counts in WAIT. expo_rd_en is a pop strobe that only
   // fires when expo_empty is low; the popped word is presented on the following cycle.
   assign op_cnt_d = (&op_cnt_q) ? op_cnt_q : op_cnt_q + CNT_W'(1);

   // Combinational so the FIFO word lands exactly in LOAD, one cycle after the strobe.
   assign expo_rd_en = (state_q == S_FETCH) && !expo_empty;
   assign mm_start   = mm_start_q;
   assign mm_op      = mm_op_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign err        = err_q;
   assign op_cnt     = op_cnt_q;
   assign dbg_state  = state_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= S_IDLE;
         mm_op_q    <= OP_CONV_IN;
         op_cnt_q   <= '0;
         word_q     <= '0;
         bit_q      <= '0;
         sh_q       <= '0;
         found_q    <= 1'b0;
         dummy_q    <= 1'b0;
         mm_start_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         mm_start_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  dummy_q    <= dummy_en;
                  op_cnt_q   <= '0;
                  found_q    <= 1'b0;
                  word_q     <= '0;
                  mm_op_q    <= OP_CONV_IN;
                  mm_start_q <= 1'b1;
                  busy_q     <= 1'b1;
                  state_q    <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               op_cnt_q <= op_cnt_d;
               state_q  <= S_WAIT;
            end
            S_WAIT: begin
               if (mm_done) begin
                  case (mm_op_q)
                     OP_CONV_IN:       state_q <= S_FETCH;
                     OP_SQR:           state_q <= S_MULCHK;
                     OP_MUL, OP_DUMMY: state_q <= S_ADV;
                     default: begin
                        err_q   <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_FIN;
                     end
                  endcase
               end
            end
            S_FETCH: begin
               if (!expo_empty) state_q <= S_LOAD;
            end
            S_LOAD: begin
               sh_q    <= expo_data;
               bit_q   <= 5'd31;
               state_q <= S_SCAN;
            end
            S_SCAN: begin
               // The leading one costs nothing: CONV_IN already left the base in the accumulator.
               if (found_q) begin
                  mm_op_q    <= OP_SQR;
                  mm_start_q <= 1'b1;
                  state_q    <= S_ISSUE;
               end else begin
                  if (sh_q[31]) found_q <= 1'b1;
                  state_q <= S_ADV;
               end
            end
            S_MULCHK: begin
               if (sh_q[31]) begin
                  mm_op_q    <= OP_MUL;
                  mm_start_q <= 1'b1;
                  state_q    <= S_ISSUE;
               end else if (dummy_q) begin
                  mm_op_q    <= OP_DUMMY;
                  mm_start_q <= 1'b1;
                  state_q    <= S_ISSUE;
               end else begin
                  state_q <= S_ADV;
               end
            end
            S_ADV: begin
               sh_q <= {sh_q[30:0], 1'b0};
               if (bit_q != 5'd0) begin
                  bit_q   <= bit_q - 5'd1;
                  state_q <= S_SCAN;
               end else if (word_q < LAST_WORD) begin
                  word_q  <= word_q + WW'(1);
                  state_q <= S_FETCH;
               end else if (found_q) begin
                  mm_op_q    <= OP_CONV_OUT;
                  mm_start_q <= 1'b1;
                  state_q    <= S_ISSUE;
               end else begin
                  err_q   <= 1'b1;
                  done_q  <= 1'b1;
                  state_q <= S_FIN;
               end
            end
            S_FIN: begin
               done_q  <= 1'b0;
               err_q   <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule
